dense_sequencer: RTL

//  Sequences one frame of the final dense (fully connected) layer of the people-tracking CNN.
//  - Accepts a 24x24 feature map, one element per handshake.
//  - Drives the weight-ROM address for each element.
//  - Aligns each pixel with its weight word across ROM latency.
//  - Accumulates both position outputs.
//  - Emits one clamped (hcount, vcount) prediction per frame.
//  - Sits between the last conv/pool stage and the tracking overlay logic.

---
 rtl/dense_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dense_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dense_sequencer: streams one 24x24 feature frame through the dense layer and
// emits a clamped (hcount, vcount) position prediction.   Rev 1.0
// ============================================================================
module dense_sequencer #(
  parameter int N_ELEM  = 576,
  parameter int PIX_W   = 16,
  parameter int W_W     = 16,
  parameter int ACC_W   = 48,
  parameter int FRAC    = 8,
  parameter int ROM_LAT = 2,
  parameter int OUT_MAX = 23,
  parameter int ADDR_W  = $clog2(N_ELEM)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic                    pixel_valid_in,
  output logic                    pixel_ready_out,
  input  logic signed [PIX_W-1:0] pixel_data_in,
  output logic [ADDR_W-1:0]       weight_addr_out,
  input  logic [2*W_W-1:0]        weight_data_in,
  output logic                    busy_out,
  output logic                    data_valid_out,
  output logic [4:0]              hcount_pred,
  output logic [4:0]              vcount_pred
);

  localparam int PROD_W = PIX_W + W_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       elem_cnt_q, elem_cnt_d;
  logic signed [PIX_W-1:0] dly_pix_q [ROM_LAT];
  logic [ROM_LAT-1:0]      dly_vld_q;
  logic signed [PROD_W-1:0] prod_h_q, prod_v_q;
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_h_q, acc_v_q;

  logic accept;
  logic last_elem;
  logic frame_start;
  logic drained;
  logic signed [W_W-1:0] w_h, w_v;

  assign accept          = pixel_valid_in && pixel_ready_out;
  assign last_elem       = (elem_cnt_q == ADDR_W'(N_ELEM - 1));
  assign frame_start     = (state_q == S_IDLE) && start_in && !abort_in;
  assign drained         = (dly_vld_q == '0) && !prod_vld_q;
  assign w_h             = $signed(weight_data_in[W_W-1:0]);
  assign w_v             = $signed(weight_data_in[2*W_W-1:W_W]);

  assign pixel_ready_out = (state_q == S_STREAM);
  assign busy_out        = (state_q != S_IDLE);
  assign weight_addr_out = (state_q == S_STREAM) ? elem_cnt_q : '0;

  // Floor shift, then saturate into the 0..OUT_MAX screen coordinate range.
  function automatic logic [4:0] clamp_pred(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC;
    if (sh < 0)
      return 5'd0;
    else if (sh > ACC_W'(OUT_MAX))
      return 5'(OUT_MAX);
    else
      return sh[4:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_STREAM;
          elem_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (accept)
          elem_cnt_d = elem_cnt_q + 1'b1;
        if (abort_in)
          state_d = S_IDLE;
        else if (accept && last_elem)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_in)
          state_d = S_IDLE;
        else if (drained)
          state_d = S_OUTPUT;
      end
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      elem_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
    end
  end

  // Each delay-line slot carries its own valid so stalls become bubbles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ROM_LAT; i++) dly_pix_q[i] <= '0;
      dly_vld_q <= '0;
    end else begin
      dly_pix_q[0] <= pixel_data_in;
      dly_vld_q[0] <= accept && !abort_in;
      for (int i = 1; i < ROM_LAT; i++) begin
        dly_pix_q[i] <= dly_pix_q[i-1];
        dly_vld_q[i] <= dly_vld_q[i-1] && !abort_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prod_h_q   <= '0;
      prod_v_q   <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_h_q   <= dly_pix_q[ROM_LAT-1] * w_h;
      prod_v_q   <= dly_pix_q[ROM_LAT-1] * w_v;
      prod_vld_q <= dly_vld_q[ROM_LAT-1] && !abort_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_h_q <= '0;
      acc_v_q <= '0;
    end else if (frame_start) begin
      acc_h_q <= '0;
      acc_v_q <= '0;
    end else if (prod_vld_q) begin
      acc_h_q <= acc_h_q + {{(ACC_W-PROD_W){prod_h_q[PROD_W-1]}}, prod_h_q};
      acc_v_q <= acc_v_q + {{(ACC_W-PROD_W){prod_v_q[PROD_W-1]}}, prod_v_q};
    end
  end

  // Predictions only move on a completed, non-aborted frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_pred    <= '0;
      vcount_pred    <= '0;
      data_valid_out <= 1'b0;
    end else if (state_q == S_OUTPUT && !abort_in) begin
      hcount_pred    <= clamp_pred(acc_h_q);
      vcount_pred    <= clamp_pred(acc_v_q);
      data_valid_out <= 1'b1;
    end else begin
      data_valid_out <= 1'b0;
    end
  end

endmodule
`default_nettype wire
